control_sequencer: RTL

Hardwired control unit for the phase-2 CPU datapath. Runs the fetch cycle, decodes the opcode held in IR, and issues one set of datapath control strobes per clock. The ld, ldi, st, ALU register, addi, nop and halt instructions are supported. It drives the same strobe inputs that phase-2 benches drive by hand, so `datapath` runs programs from memory without a hand-written stimulus sequence.

---
 rtl/control_sequencer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the phase-2 CPU datapath.
// Fetches an instruction, decodes its opcode from IR, and issues one set of
// datapath control strobes per clock. A single state register steps through
// RESET, T0..T7 and HALT. Strobes are decoded from that register and from IR.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        RAMwrite,
  output logic        IRin,
  output logic        RYin,
  output logic        RZinLo,
  output logic        RZoutLo,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        RCout,
  output logic [2:0]  alu_op,
  output logic        run,
  output logic [2:0]  step
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    IC_LD, IC_LDI, IC_ST, IC_ALU, IC_ADDI, IC_NOP, IC_HALT
  } iclass_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_t;

  // All datapath strobes in one bundle so each state can clear them in one go.
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic mdr_read;
    logic ram_write;
    logic ir_in;
    logic ry_in;
    logic rz_in_lo;
    logic rz_out_lo;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic rc_out;
  } strobes_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t         state;
  iclass_t        iclass;
  alu_t           alu_sel;
  strobes_t       s;
  logic           last_step;
  logic [OPW-1:0] opcode;
  logic           unused_ir_bits;

  assign opcode = ir[31 -: OPW];

  // Register fields are decoded by the datapath, not here.
  assign unused_ir_bits = ^ir[31-OPW:0];

  // Opcode decode into an instruction class plus the ALU function it needs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can hold an old value and infer a latch.
    iclass  = IC_NOP;
    alu_sel = ALU_ADD;
    case (opcode)
      OP_LD:   iclass = IC_LD;
      OP_LDI:  iclass = IC_LDI;
      OP_ST:   iclass = IC_ST;
      OP_ADD:  begin iclass = IC_ALU; alu_sel = ALU_ADD; end
      OP_SUB:  begin iclass = IC_ALU; alu_sel = ALU_SUB; end
      OP_AND:  begin iclass = IC_ALU; alu_sel = ALU_AND; end
      OP_OR:   begin iclass = IC_ALU; alu_sel = ALU_OR;  end
      OP_ADDI: iclass = IC_ADDI;
      OP_HALT: iclass = IC_HALT;
      default: iclass = IC_NOP;  // nop and every undefined opcode
    endcase
  end

  // Final T-step of the instruction in flight; stop is honoured only here.
  always_comb begin
    last_step = 1'b0;
    case (state)
      S_T3:    last_step = (iclass == IC_NOP) || (iclass == IC_HALT);
      S_T5:    last_step = (iclass == IC_LDI) || (iclass == IC_ALU) ||
                           (iclass == IC_ADDI);
      S_T7:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  // Sequencer state: one T-step per clock, back to T0 or into HALT at the end.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RESET;
    end else begin
      // NOTE: state is updated with <= so every reader sees the value from
      // before the edge, independent of block evaluation order.
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (iclass == IC_HALT) state <= S_HALT;
          else if (last_step)    state <= stop ? S_HALT : S_T0;
          else                   state <= S_T4;
        end
        S_T4:    state <= S_T5;
        S_T5: begin
          if (last_step) state <= stop ? S_HALT : S_T0;
          else           state <= S_T6;
        end
        S_T6:    state <= S_T7;
        S_T7:    state <= stop ? S_HALT : S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Strobe decode for the current T-step and instruction class.
  always_comb begin
    s      = '0;
    alu_op = ALU_ADD;
    case (state)
      S_T0: begin
        s.pc_out   = 1'b1;
        s.mar_in   = 1'b1;
        s.inc_pc   = 1'b1;
        s.rz_in_lo = 1'b1;
      end
      S_T1: begin
        s.rz_out_lo = 1'b1;
        s.pc_in     = 1'b1;
        s.mdr_read  = 1'b1;
        s.mdr_in    = 1'b1;
      end
      S_T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      S_T3: begin
        case (iclass)
          IC_LD, IC_LDI, IC_ST: begin
            s.grb    = 1'b1;
            s.ba_out = 1'b1;
            s.ry_in  = 1'b1;
          end
          IC_ALU, IC_ADDI: begin
            s.grb   = 1'b1;
            s.r_out = 1'b1;
            s.ry_in = 1'b1;
          end
          default: s = '0;  // nop / halt / undefined: idle step
        endcase
      end
      S_T4: begin
        s.rz_in_lo = 1'b1;
        if (iclass == IC_ALU) begin
          s.grc  = 1'b1;
          s.r_out = 1'b1;
          alu_op = alu_sel;
        end else begin
          s.rc_out = 1'b1;  // base + offset, or register + immediate
        end
      end
      S_T5: begin
        s.rz_out_lo = 1'b1;
        if ((iclass == IC_LD) || (iclass == IC_ST)) begin
          s.mar_in = 1'b1;
        end else begin
          s.gra  = 1'b1;
          s.r_in = 1'b1;
        end
      end
      S_T6: begin
        s.mdr_in = 1'b1;
        if (iclass == IC_ST) begin
          s.gra   = 1'b1;
          s.r_out = 1'b1;
        end else begin
          s.mdr_read = 1'b1;
        end
      end
      S_T7: begin
        if (iclass == IC_ST) begin
          s.ram_write = 1'b1;
        end else begin
          s.mdr_out = 1'b1;
          s.gra     = 1'b1;
          s.r_in    = 1'b1;
        end
      end
      default: s = '0;  // RESET and HALT drive nothing
    endcase
  end

  // Current T-step number and run flag, both decoded from the state register.
  always_comb begin
    step = 3'd0;
    case (state)
      S_T0:    step = 3'd0;
      S_T1:    step = 3'd1;
      S_T2:    step = 3'd2;
      S_T3:    step = 3'd3;
      S_T4:    step = 3'd4;
      S_T5:    step = 3'd5;
      S_T6:    step = 3'd6;
      S_T7:    step = 3'd7;
      default: step = 3'd0;
    endcase
  end

  assign run = (state != S_HALT);

  assign PCout    = s.pc_out;
  assign PCin     = s.pc_in;
  assign IncPC    = s.inc_pc;
  assign MARin    = s.mar_in;
  assign MDRin    = s.mdr_in;
  assign MDRout   = s.mdr_out;
  assign MDRread  = s.mdr_read;
  assign RAMwrite = s.ram_write;
  assign IRin     = s.ir_in;
  assign RYin     = s.ry_in;
  assign RZinLo   = s.rz_in_lo;
  assign RZoutLo  = s.rz_out_lo;
  assign Gra      = s.gra;
  assign Grb      = s.grb;
  assign Grc      = s.grc;
  assign Rin      = s.r_in;
  assign Rout     = s.r_out;
  assign BAout    = s.ba_out;
  assign RCout    = s.rc_out;

endmodule
